// File: rtl/muntjac_tl_host_arbiter.sv
// N-link TileLink host arbiter: merges host A channels onto one device link with
// burst locking, and steers device D beats back to hosts by source-ID match.

module muntjac_tl_host_arbiter_lane #(
  parameter int                     SourceWidth = 4,
  parameter logic [SourceWidth-1:0] Base        = '0,
  parameter logic [SourceWidth-1:0] Mask        = '0
) (
  input  logic                   grant,
  input  logic                   route,
  input  logic                   dev_a_ready,
  input  logic                   dev_d_valid,
  input  logic [SourceWidth-1:0] d_source,
  output logic                   d_match,
  output logic                   host_a_ready,
  output logic                   host_d_valid
);
  assign d_match      = (d_source & ~Mask) == (Base & ~Mask);
  assign host_a_ready = grant & dev_a_ready;
  assign host_d_valid = route & dev_d_valid;
endmodule

module muntjac_tl_host_arbiter #(
  parameter int NumLinks      = 4,
  parameter int SourceWidth   = 4,
  parameter int DataWidth     = 64,
  parameter int APayloadWidth = 128,
  parameter int DPayloadWidth = 72,
  parameter logic [NumLinks-1:0][SourceWidth-1:0] SourceBase = '0,
  parameter logic [NumLinks-1:0][SourceWidth-1:0] SourceMask = '0
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              rr_mode_i,
  input  logic [NumLinks-1:0]               host_a_valid_i,
  output logic [NumLinks-1:0]               host_a_ready_o,
  input  logic [NumLinks*3-1:0]             host_a_opcode_i,
  input  logic [NumLinks*3-1:0]             host_a_size_i,
  input  logic [NumLinks*APayloadWidth-1:0] host_a_payload_i,
  output logic                              dev_a_valid_o,
  input  logic                              dev_a_ready_i,
  output logic [2:0]                        dev_a_opcode_o,
  output logic [2:0]                        dev_a_size_o,
  output logic [APayloadWidth-1:0]          dev_a_payload_o,
  input  logic                              dev_d_valid_i,
  output logic                              dev_d_ready_o,
  input  logic [2:0]                        dev_d_opcode_i,
  input  logic [2:0]                        dev_d_size_i,
  input  logic [SourceWidth-1:0]            dev_d_source_i,
  input  logic [DPayloadWidth-1:0]          dev_d_payload_i,
  output logic [NumLinks-1:0]               host_d_valid_o,
  input  logic [NumLinks-1:0]               host_d_ready_i,
  output logic [2:0]                        host_d_opcode_o,
  output logic [2:0]                        host_d_size_o,
  output logic [SourceWidth-1:0]            host_d_source_o,
  output logic [DPayloadWidth-1:0]          host_d_payload_o,
  output logic [NumLinks-1:0]               a_grant_o,
  output logic                              d_unmatched_o
);
  localparam int IdxW      = $clog2(NumLinks);
  localparam int DataBytes = DataWidth / 8;
  localparam int OffW      = $clog2(DataBytes);
  localparam int CntW      = 8;

  typedef enum logic {A_IDLE, A_LOCKED} a_state_e;
  typedef enum logic {D_IDLE, D_LOCKED} d_state_e;

  // Remaining beats after the first one; single-beat messages return 0.
  function automatic logic [CntW-1:0] beats_m1(input logic multi, input logic [2:0] size);
    int sz;
    sz = int'(size);
    if (multi && sz > OffW) return CntW'((1 << (sz - OffW)) - 1);
    return '0;
  endfunction

  logic [NumLinks-1:0][2:0]               a_opcode, a_size;
  logic [NumLinks-1:0][APayloadWidth-1:0] a_payload;
  assign a_opcode  = host_a_opcode_i;
  assign a_size    = host_a_size_i;
  assign a_payload = host_a_payload_i;

  a_state_e        a_state;
  logic [CntW-1:0] a_left;
  logic [IdxW-1:0] a_lock_idx, rr_ptr, start, pick_idx, gnt_idx;
  logic [IdxW:0]   cand;
  logic            pick_vld, gnt_any, a_locked, a_hs, a_multi;
  logic [CntW-1:0] a_first_left;

  // Scan from the highest offset down so the closest valid link to 'start' wins.
  always_comb begin
    start    = rr_mode_i ? rr_ptr : '0;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int off = NumLinks - 1; off >= 0; off--) begin
      cand = {1'b0, start} + (IdxW+1)'(off);
      if (cand >= (IdxW+1)'(NumLinks)) cand = cand - (IdxW+1)'(NumLinks);
      if (host_a_valid_i[cand[IdxW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IdxW-1:0];
      end
    end
  end

  assign a_locked        = (a_state == A_LOCKED);
  assign gnt_idx         = a_locked ? a_lock_idx : pick_idx;
  assign gnt_any         = a_locked | pick_vld;
  assign a_grant_o       = gnt_any ? (NumLinks'(1) << gnt_idx) : '0;
  assign dev_a_valid_o   = gnt_any & host_a_valid_i[gnt_idx];
  assign dev_a_opcode_o  = a_opcode[gnt_idx];
  assign dev_a_size_o    = a_size[gnt_idx];
  assign dev_a_payload_o = a_payload[gnt_idx];
  assign a_hs            = dev_a_valid_o & dev_a_ready_i;
  assign a_multi         = (dev_a_opcode_o == 3'd0) | (dev_a_opcode_o == 3'd1);
  assign a_first_left    = beats_m1(a_multi, dev_a_size_o);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      a_state    <= A_IDLE;
      a_left     <= '0;
      a_lock_idx <= '0;
      rr_ptr     <= '0;
    end else if (a_hs) begin
      case (a_state)
        A_IDLE: begin
          rr_ptr <= (pick_idx == IdxW'(NumLinks - 1)) ? '0 : pick_idx + IdxW'(1);
          if (a_first_left != '0) begin
            a_state    <= A_LOCKED;
            a_left     <= a_first_left;
            a_lock_idx <= pick_idx;
          end
        end
        A_LOCKED: begin
          a_left <= a_left - CntW'(1);
          if (a_left == CntW'(1)) a_state <= A_IDLE;
        end
      endcase
    end
  end

  d_state_e          d_state;
  logic [CntW-1:0]   d_left, d_first_left;
  logic [IdxW-1:0]   d_lock_idx, d_idx, route_idx;
  logic [NumLinks-1:0] d_match, route;
  logic              d_hit, d_locked, route_ok, d_hs, d_multi;

  always_comb begin
    d_idx = '0;
    for (int k = NumLinks - 1; k >= 0; k--)
      if (d_match[k]) d_idx = IdxW'(k);
  end

  assign d_hit        = |d_match;
  assign d_locked     = (d_state == D_LOCKED);
  assign route_idx    = d_locked ? d_lock_idx : d_idx;
  assign route_ok     = d_locked | d_hit;
  assign route        = route_ok ? (NumLinks'(1) << route_idx) : '0;
  // Unmatched beats are swallowed so a stray source cannot wedge the device.
  assign dev_d_ready_o = route_ok ? host_d_ready_i[route_idx] : 1'b1;
  assign d_hs         = dev_d_valid_i & dev_d_ready_o;
  assign d_multi      = (dev_d_opcode_i == 3'd1) | (dev_d_opcode_i == 3'd5);
  assign d_first_left = beats_m1(d_multi, dev_d_size_i);

  assign host_d_opcode_o  = dev_d_opcode_i;
  assign host_d_size_o    = dev_d_size_i;
  assign host_d_source_o  = dev_d_source_i;
  assign host_d_payload_o = dev_d_payload_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_state       <= D_IDLE;
      d_left        <= '0;
      d_lock_idx    <= '0;
      d_unmatched_o <= 1'b0;
    end else begin
      if (dev_d_valid_i && !route_ok) d_unmatched_o <= 1'b1;
      if (d_hs) begin
        case (d_state)
          D_IDLE: begin
            if (d_hit && d_first_left != '0) begin
              d_state    <= D_LOCKED;
              d_left     <= d_first_left;
              d_lock_idx <= d_idx;
            end
          end
          D_LOCKED: begin
            d_left <= d_left - CntW'(1);
            if (d_left == CntW'(1)) d_state <= D_IDLE;
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < NumLinks; i++) begin : g_lane
    muntjac_tl_host_arbiter_lane #(
      .SourceWidth (SourceWidth),
      .Base        (SourceBase[i]),
      .Mask        (SourceMask[i])
    ) u_lane (
      .grant        (a_grant_o[i]),
      .route        (route[i]),
      .dev_a_ready  (dev_a_ready_i),
      .dev_d_valid  (dev_d_valid_i),
      .d_source     (dev_d_source_i),
      .d_match      (d_match[i]),
      .host_a_ready (host_a_ready_o[i]),
      .host_d_valid (host_d_valid_o[i])
    );
  end
endmodule

// File: tb/tb_muntjac_tl_host_arbiter.sv
// Randomised bench for muntjac_tl_host_arbiter against a burst-level model of
// host requests, grant ownership and D routing.

module tb_muntjac_tl_host_arbiter;
  localparam int N = 4, SW = 4, AW = 128, DW = 72;
  localparam logic [N-1:0][SW-1:0] BASE = {4'd3, 4'd2, 4'd1, 4'd0};

  logic clk, rst_n, rr_mode;
  logic [N-1:0] a_valid, a_ready;
  logic [N*3-1:0] a_opcode, a_size;
  logic [N*AW-1:0] a_payload;
  logic dev_a_valid, dev_a_ready;
  logic [2:0] dev_a_opcode, dev_a_size;
  logic [AW-1:0] dev_a_payload;
  logic d_valid, d_ready;
  logic [2:0] d_opcode, d_size;
  logic [SW-1:0] d_source;
  logic [DW-1:0] d_payload;
  logic [N-1:0] hd_valid, hd_ready;
  logic [2:0] hd_opcode, hd_size;
  logic [SW-1:0] hd_source;
  logic [DW-1:0] hd_payload;
  logic [N-1:0] grant;
  logic unmatched;

  muntjac_tl_host_arbiter #(
    .NumLinks(N), .SourceWidth(SW), .DataWidth(64), .APayloadWidth(AW),
    .DPayloadWidth(DW), .SourceBase(BASE), .SourceMask('0)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .rr_mode_i(rr_mode),
    .host_a_valid_i(a_valid), .host_a_ready_o(a_ready),
    .host_a_opcode_i(a_opcode), .host_a_size_i(a_size), .host_a_payload_i(a_payload),
    .dev_a_valid_o(dev_a_valid), .dev_a_ready_i(dev_a_ready),
    .dev_a_opcode_o(dev_a_opcode), .dev_a_size_o(dev_a_size), .dev_a_payload_o(dev_a_payload),
    .dev_d_valid_i(d_valid), .dev_d_ready_o(d_ready),
    .dev_d_opcode_i(d_opcode), .dev_d_size_i(d_size), .dev_d_source_i(d_source),
    .dev_d_payload_i(d_payload),
    .host_d_valid_o(hd_valid), .host_d_ready_i(hd_ready),
    .host_d_opcode_o(hd_opcode), .host_d_size_o(hd_size), .host_d_source_o(hd_source),
    .host_d_payload_o(hd_payload),
    .a_grant_o(grant), .d_unmatched_o(unmatched)
  );

  initial begin clk = 0; forever #5 clk = ~clk; end

  // Model: per-host outstanding burst, who owns the A path, RR pointer, D state.
  int a_rem[N];
  logic [2:0] m_op[N], m_sz[N];
  logic [AW-1:0] m_pay[N];
  int a_owner, rr;
  int d_rem, d_owner;
  logic [2:0] md_op, md_sz;
  logic [SW-1:0] md_src;
  logic [DW-1:0] md_pay;
  bit unm, mode_rand;
  int a_start_pct, a_rdy_pct, d_start_pct, d_rdy_pct;
  logic [N-1:0] obs_grant, obs_hdv;
  int n_chk, n_err;

  task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int beats(input bit is_a, input logic [2:0] op, input logic [2:0] sz);
    bit multi;
    multi = is_a ? (op <= 3'd1) : (op == 3'd1 || op == 3'd5);
    return (multi && sz > 3'd3) ? (1 << (int'(sz) - 3)) : 1;
  endfunction

  function automatic logic [AW-1:0] rnd_a();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [DW-1:0] rnd_d();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  task automatic new_a(input int i, input int op, input int sz);
    m_op[i] = 3'(op); m_sz[i] = 3'(sz);
    a_rem[i] = beats(1'b1, m_op[i], m_sz[i]);
    m_pay[i] = rnd_a();
  endtask

  task automatic new_d(input int src, input int op, input int sz);
    md_src = SW'(src); md_op = 3'(op); md_sz = 3'(sz);
    d_rem = beats(1'b0, md_op, md_sz);
    md_pay = rnd_d();
  endtask

  // One clock: drive just after posedge, check and advance the model at negedge.
  task automatic cycle();
    int g, r;
    logic [N-1:0] exp_g, exp_hdv;
    bit exp_v, exp_rdy;
    #1;
    for (int i = 0; i < N; i++)
      if (a_rem[i] == 0 && $urandom_range(99) < a_start_pct)
        new_a(i, $urandom_range(7), $urandom_range(5));
    if (d_rem == 0 && $urandom_range(99) < d_start_pct)
      new_d(($urandom_range(4) == 0) ? 9 : $urandom_range(3), $urandom_range(7), $urandom_range(6));
    if (mode_rand && $urandom_range(9) == 0) rr_mode = ~rr_mode;
    for (int i = 0; i < N; i++) begin
      a_valid[i] = a_rem[i] > 0;
      a_opcode[i*3 +: 3] = m_op[i];
      a_size[i*3 +: 3] = m_sz[i];
      a_payload[i*AW +: AW] = m_pay[i];
      hd_ready[i] = $urandom_range(99) < d_rdy_pct;
    end
    dev_a_ready = $urandom_range(99) < a_rdy_pct;
    d_valid = d_rem > 0;
    d_opcode = md_op; d_size = md_sz; d_source = md_src; d_payload = md_pay;
    @(negedge clk);

    g = a_owner;
    if (g < 0)
      for (int k = 0; k < N; k++) begin
        int j;
        j = rr_mode ? (rr + k) % N : k;
        if (g < 0 && a_rem[j] > 0) g = j;
      end
    exp_g = (g >= 0) ? N'(1) << g : '0;
    exp_v = (g >= 0) && a_rem[g] > 0;
    obs_grant = grant;
    chk("a_grant", grant, exp_g);
    chk("dev_a_valid", dev_a_valid, exp_v);
    chk("host_a_ready", a_ready, dev_a_ready ? exp_g : '0);
    if (exp_v) begin
      chk("dev_a_beat", {dev_a_opcode, dev_a_size, dev_a_payload}, {m_op[g], m_sz[g], m_pay[g]});
      if (dev_a_ready) begin
        if (a_owner < 0) begin
          rr = (g + 1) % N;
          if (beats(1'b1, m_op[g], m_sz[g]) > 1) a_owner = g;
        end
        a_rem[g]--;
        m_pay[g] = rnd_a();
        if (a_rem[g] == 0 && a_owner == g) a_owner = -1;
      end
    end

    chk("d_unmatched", unmatched, unm);
    obs_hdv = hd_valid;
    if (d_rem > 0) begin
      r = d_owner;
      if (r < 0)
        for (int k = 0; k < N; k++) if (r < 0 && md_src == BASE[k]) r = k;
      exp_hdv = (r >= 0) ? N'(1) << r : '0;
      exp_rdy = (r >= 0) ? hd_ready[r] : 1'b1;
      chk("host_d_valid", hd_valid, exp_hdv);
      chk("dev_d_ready", d_ready, exp_rdy);
      chk("host_d_fields", {hd_opcode, hd_size, hd_source, hd_payload}, {md_op, md_sz, md_src, md_pay});
      if (r < 0) unm = 1;
      if (exp_rdy) begin
        if (d_owner < 0 && r >= 0 && beats(1'b0, md_op, md_sz) > 1) d_owner = r;
        d_rem--;
        md_pay = rnd_d();
        if (d_rem == 0) d_owner = -1;
      end
    end else begin
      chk("host_d_idle", hd_valid, '0);
    end
    @(posedge clk);
  endtask

  task automatic quiet();
    a_start_pct = 0; d_start_pct = 0; a_rdy_pct = 100; d_rdy_pct = 100; mode_rand = 0;
  endtask

  initial begin
    int t;
    n_chk = 0; n_err = 0;
    a_owner = -1; d_owner = -1; rr = 0; d_rem = 0; unm = 0;
    for (int i = 0; i < N; i++) begin a_rem[i] = 0; m_op[i] = 0; m_sz[i] = 0; m_pay[i] = '0; end
    md_op = 0; md_sz = 0; md_src = 0; md_pay = '0;
    rst_n = 0; rr_mode = 0; a_valid = 0; a_opcode = 0; a_size = 0; a_payload = 0;
    dev_a_ready = 0; d_valid = 0; d_opcode = 0; d_size = 0; d_source = 0; d_payload = 0;
    hd_ready = 0;
    quiet();
    #3;
    chk("rst_grant", grant, '0);
    chk("rst_dev_a_valid", dev_a_valid, 1'b0);
    chk("rst_host_d_valid", hd_valid, '0);
    chk("rst_unmatched", unmatched, 1'b0);
    #9 rst_n = 1;
    @(posedge clk);

    // Fixed priority: 0 before 2.
    new_a(0, 4, 0); new_a(2, 4, 0);
    cycle(); chk("fix_first", obs_grant, 4'b0001);
    cycle(); chk("fix_second", obs_grant, 4'b0100);

    // Round robin with every link busy.
    rr_mode = 1;
    t = rr;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < N; i++) if (a_rem[i] == 0) new_a(i, 4, 0);
      cycle();
      chk("rr_rotate", obs_grant, N'(1) << ((t + k) % N));
    end
    for (int k = 0; k < 4; k++) cycle();

    // 4-beat PutFullData on link 1 holds the grant against link 0.
    rr_mode = 0; a_rdy_pct = 50;
    new_a(1, 0, 5);
    t = 0;
    while (a_rem[1] == 4 && t < 60) begin cycle(); t++; end
    new_a(0, 4, 0);
    while (a_rem[1] > 0 && t < 200) begin cycle(); t++; end
    chk("burst_timeout", a_rem[1], 0);
    a_rdy_pct = 100;
    cycle(); chk("burst_next", obs_grant, 4'b0001);

    // 8-beat AccessAckData to source 3 with stalls.
    d_rdy_pct = 0;
    new_d(3, 1, 6);
    cycle(); chk("d_route3", obs_hdv, 4'b1000);
    d_rdy_pct = 50; t = 0;
    while (d_rem > 0 && t < 200) begin cycle(); t++; end
    chk("d_burst_timeout", d_rem, 0);

    // Unmatched source is dropped and flagged.
    d_rdy_pct = 0;
    new_d(9, 0, 0);
    cycle(); chk("unm_no_host", obs_hdv, '0);
    cycle(); chk("unm_sticky", unmatched, 1'b1);
    cycle();

    // Random traffic.
    mode_rand = 1; a_start_pct = 40; a_rdy_pct = 70; d_start_pct = 50; d_rdy_pct = 70;
    for (int k = 0; k < 2000; k++) cycle();

    // Drain, then reset in the middle of a 4-beat burst.
    quiet(); t = 0;
    while ((a_rem[0] + a_rem[1] + a_rem[2] + a_rem[3] + d_rem) > 0 && t < 300) begin cycle(); t++; end
    chk("drain_timeout", a_rem[0] + a_rem[1] + a_rem[2] + a_rem[3] + d_rem, 0);
    rr_mode = 1;
    new_a(1, 0, 5);
    cycle(); cycle();
    #1;
    rst_n = 0;
    for (int i = 0; i < N; i++) a_rem[i] = 0;
    a_owner = -1; rr = 0; d_owner = -1; d_rem = 0; unm = 0;
    a_valid = 0; d_valid = 0;
    #1;
    chk("mid_rst_grant", grant, '0);
    chk("mid_rst_dev_a_valid", dev_a_valid, 1'b0);
    chk("mid_rst_unmatched", unmatched, 1'b0);
    #1 rst_n = 1;
    @(posedge clk);
    new_a(3, 4, 0); new_a(1, 4, 0);
    cycle(); chk("post_rst_rr", obs_grant, 4'b0010);
    mode_rand = 1; a_start_pct = 30; a_rdy_pct = 80; d_start_pct = 30; d_rdy_pct = 80;
    for (int k = 0; k < 300; k++) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
